param_datapath: RTL and testbench
=================================

PARAM_DATAPATH -- requirements
Module: param_datapath

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data, bus and register width.
REQ-002 SHALL have parameter NUM_REGS, default 16, meaning general register count; RA_W = clog2(NUM_REGS).
REQ-003 SHALL have parameter ADDR_W, default 9, meaning memory address width (low bits of MAR).
REQ-004 SHALL have ports: clk in 1, the single clock; clr in 1, synchronous active-high reset.
REQ-005 SHALL have ports: cmd_valid in 1, command offered; cmd_ready out 1, command accepted when both high.
REQ-006 SHALL have ports: cmd_op in 4, opcode; cmd_ra/cmd_rb/cmd_rc in RA_W each, register selectors; cmd_imm in DATA_W, immediate.
REQ-007 SHALL have ports: done out 1, one-cycle completion pulse; err out 1, one-cycle illegal-op pulse; busy out 1, not idle.
REQ-008 SHALL have ports: mem_req out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W; mem_ack in 1.
REQ-009 SHALL have ports: bus_contents out DATA_W, current bus value; flag_z out 1 and flag_n out 1, result flags.

Function
REQ-010 SHALL decode opcodes 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR (logical, amount = Rc[clog2(DATA_W)-1:0]), 6 ADDI, 7 LD, 8 ST; 9-15 illegal.
REQ-011 SHALL drive cmd_ready high only in state IDLE; commands offered while busy are not accepted and produce no effect.
REQ-012 SHALL, for ALU ops, sequence IDLE -> T1 (Rb onto bus, bus -> Y) -> T2 (Rc, or cmd_imm for ADDI, onto bus; ALU(Y, bus) -> Z) -> T3 (Z -> Ra) -> IDLE, one state per cycle.
REQ-013 SHALL latch cmd_op/ra/rb/rc/imm on acceptance and use only the latched copies thereafter.
REQ-014 SHALL pulse done for exactly one cycle, in the cycle after the Ra write edge; ALU-op latency is 4 cycles from the acceptance edge to done high.
REQ-015 SHALL compute results modulo 2^DATA_W; SUB = Y - bus in two's complement; shift amounts >= DATA_W are impossible by truncation.
REQ-016 SHALL update flag_z (Z == 0) and flag_n (Z MSB) on the T2 edge of ALU ops only; LD/ST leave flags unchanged.
REQ-017 SHALL, for LD/ST, sequence T1 (base -> Y, base = 0 when Rb index is 0, else Rb) -> T2 (Y + imm -> Z) -> T3 (Z[ADDR_W-1:0] -> MAR).
REQ-018 SHALL, for LD, continue MEM (mem_req=1, mem_we=0) until the mem_ack edge, capturing mem_rdata into MDR; then T5 (MDR -> Ra); then done.
REQ-019 SHALL, for ST, continue T4 (Ra -> MDR), then MEM (mem_req=1, mem_we=1, mem_wdata=MDR) until the mem_ack edge; then done.
REQ-020 SHALL hold mem_req, mem_we, mem_addr and mem_wdata stable from assertion until the ack edge, and deassert mem_req on the cycle after ack.
REQ-021 SHALL ignore mem_ack when mem_req is low; the wait in MEM is unbounded.
REQ-022 SHALL treat R0 as an ordinary register for writes and ALU reads; only the LD/ST base path substitutes zero.
REQ-023 SHALL, on an illegal opcode, pulse err and done together one cycle after acceptance, with no register, flag or memory change.
REQ-024 SHALL drive bus_contents from exactly one source per state, and to 0 in IDLE.

Reset
REQ-025 SHALL, while clr is high at a clock edge, set state IDLE, all registers, Y, Z, MAR and MDR to 0, flags 0, done/err/mem_req/mem_we 0; this applies mid-operation, including during MEM.
REQ-026 SHALL, after reset, assert cmd_ready on the first cycle with clr low.

Structure
REQ-027 SHALL place the opcode and state enumerations and opcode constants in shared package dp_pkg.
REQ-028 SHALL implement the ALU as combinational sub-module dp_alu (parameter DATA_W; inputs a, b, op; output result).

Verification
REQ-029 SHALL verify: R1=5, R2=7, ADD ra=3 rb=1 rc=2 -> done 4 cycles after acceptance, R3=12, flag_z=0.
REQ-030 SHALL verify: R1=3, R2=3, SUB ra=4 -> R4=0 and flag_z=1; then SUB with R1=0, R2=1 -> result 0xFFFFFFFF and flag_n=1.
REQ-031 SHALL verify: ST ra=5 (R5=0xA5A5A5A5), rb=0, imm=0x10, ack after 3 wait cycles -> mem_addr=0x010, mem_we=1, mem_wdata held stable until ack.
REQ-032 SHALL verify: LD ra=6, rb=2 (R2=0x20), imm=4, mem_rdata=0xDEADBEEF -> mem_addr=0x024, R6=0xDEADBEEF.
REQ-033 SHALL verify: cmd_op=12 -> err and done pulse together, no register change; cmd_valid held high while busy -> command accepted only after return to IDLE.
REQ-034 SHALL verify: clr asserted during MEM wait -> mem_req 0 on the next cycle, all registers 0, cmd_ready 1 on the cycle after clr falls.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared opcode and sequencer-state definitions for the bus-based datapath.
package dp_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_SHL  = 4'd4,
      OP_SHR  = 4'd5,
      OP_ADDI = 4'd6,
      OP_LD   = 4'd7,
      OP_ST   = 4'd8
   } op_e;

   localparam logic [3:0] OP_LAST_LEGAL = OP_ST;

   typedef enum logic [2:0] {
      S_IDLE,
      S_T1,
      S_T2,
      S_T3,
      S_T4,
      S_MEM,
      S_T5
   } state_e;

   function automatic logic is_legal(input logic [3:0] op);
      return op <= OP_LAST_LEGAL;
   endfunction

   function automatic logic is_mem(input logic [3:0] op);
      return (op == OP_LD) || (op == OP_ST);
   endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU; any opcode other than SUB/AND/OR/SHL/SHR adds,
// which covers ADD, ADDI and the LD/ST address computation.
module dp_alu
   import dp_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [3:0]        op,
   output logic [DATA_W-1:0] result
);

   localparam int SH_W = $clog2(DATA_W);

   always_comb begin
      result = a + b;
      case (op)
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_SHL:  result = a << b[SH_W-1:0];
         OP_SHR:  result = a >> b[SH_W-1:0];
         default: result = a + b;
      endcase
   end

endmodule

// File: rtl/param_datapath.sv
// Single-bus multi-cycle datapath: register file, Y/Z ALU latches, MAR/MDR
// memory port, sequenced one micro-step per clock by a small FSM.
module param_datapath
   import dp_pkg::*;
#(
   parameter  int DATA_W   = 32,
   parameter  int NUM_REGS = 16,
   parameter  int ADDR_W   = 9,
   localparam int RA_W     = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [RA_W-1:0]   cmd_ra,
   input  logic [RA_W-1:0]   cmd_rb,
   input  logic [RA_W-1:0]   cmd_rc,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic              done,
   output logic              err,
   output logic              busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [DATA_W-1:0] bus_contents,
   output logic              flag_z,
   output logic              flag_n
);

   state_e            state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [RA_W-1:0]   ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
   logic [DATA_W-1:0] imm_q, imm_d, y_q, y_d, z_q, z_d, mdr_q, mdr_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic              flag_z_q, flag_z_d, flag_n_q, flag_n_d;
   logic              done_q, done_d, err_q, err_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];

   logic              reg_we;
   logic [RA_W-1:0]   reg_wa;
   logic [DATA_W-1:0] reg_wd;
   logic [DATA_W-1:0] bus, alu_res;
   logic [3:0]        alu_op;
   logic              mem_op;

   assign mem_op = is_mem(op_q);
   assign alu_op = mem_op ? OP_ADD : op_q;

   dp_alu #(.DATA_W(DATA_W)) u_alu (
      .a      (y_q),
      .b      (bus),
      .op     (alu_op),
      .result (alu_res)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
      rc_d     = rc_q;
      imm_d    = imm_q;
      y_d      = y_q;
      z_d      = z_q;
      mar_d    = mar_q;
      mdr_d    = mdr_q;
      flag_z_d = flag_z_q;
      flag_n_d = flag_n_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      reg_we   = 1'b0;
      reg_wa   = ra_q;
      reg_wd   = z_q;
      bus      = '0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d  = cmd_op;
               ra_d  = cmd_ra;
               rb_d  = cmd_rb;
               rc_d  = cmd_rc;
               imm_d = cmd_imm;
               if (is_legal(cmd_op)) begin
                  state_d = S_T1;
               end else begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end
            end
         end
         S_T1: begin
            // Only the memory base path treats R0 as a hard zero.
            if (mem_op && rb_q == '0) bus = '0;
            else                      bus = regs_q[rb_q];
            y_d     = bus;
            state_d = S_T2;
         end
         S_T2: begin
            if (mem_op || op_q == OP_ADDI) bus = imm_q;
            else                           bus = regs_q[rc_q];
            z_d = alu_res;
            if (!mem_op) begin
               flag_z_d = (alu_res == '0);
               flag_n_d = alu_res[DATA_W-1];
            end
            state_d = S_T3;
         end
         S_T3: begin
            bus = z_q;
            if (mem_op) begin
               mar_d   = z_q[ADDR_W-1:0];
               state_d = (op_q == OP_LD) ? S_MEM : S_T4;
            end else begin
               reg_we  = 1'b1;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_T4: begin
            bus     = regs_q[ra_q];
            mdr_d   = bus;
            state_d = S_MEM;
         end
         S_MEM: begin
            bus = (op_q == OP_LD) ? mem_rdata : mdr_q;
            if (mem_ack) begin
               if (op_q == OP_LD) begin
                  mdr_d   = mem_rdata;
                  state_d = S_T5;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         S_T5: begin
            bus     = mdr_q;
            reg_we  = 1'b1;
            reg_wd  = mdr_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         ra_q     <= '0;
         rb_q     <= '0;
         rc_q     <= '0;
         imm_q    <= '0;
         y_q      <= '0;
         z_q      <= '0;
         mar_q    <= '0;
         mdr_q    <= '0;
         flag_z_q <= 1'b0;
         flag_n_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         rc_q     <= rc_d;
         imm_q    <= imm_d;
         y_q      <= y_d;
         z_q      <= z_d;
         mar_q    <= mar_d;
         mdr_q    <= mdr_d;
         flag_z_q <= flag_z_d;
         flag_n_q <= flag_n_d;
         done_q   <= done_d;
         err_q    <= err_d;
         if (reg_we) regs_q[reg_wa] <= reg_wd;
      end
   end

   assign cmd_ready    = (state_q == S_IDLE);
   assign busy         = (state_q != S_IDLE);
   assign mem_req      = (state_q == S_MEM);
   assign mem_we       = (state_q == S_MEM) && (op_q == OP_ST);
   assign mem_addr     = mar_q;
   assign mem_wdata    = mdr_q;
   assign done         = done_q;
   assign err          = err_q;
   assign flag_z       = flag_z_q;
   assign flag_n       = flag_n_q;
   assign bus_contents = bus;

endmodule

// File: tb/tb_param_datapath.sv
// Scoreboard bench for param_datapath: driver pushes model predictions at
// acceptance, a negedge monitor pops and compares on every done pulse.
module tb_param_datapath;

   localparam int DW   = 32;
   localparam int NR   = 16;
   localparam int AW   = 9;
   localparam int MEMN = 512;

   logic          clk = 1'b0;
   logic          clr;
   logic          cmd_valid, cmd_ready;
   logic [3:0]    cmd_op, cmd_ra, cmd_rb, cmd_rc;
   logic [DW-1:0] cmd_imm;
   logic          done, err, busy;
   logic          mem_req, mem_we, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata, bus_contents;
   logic          flag_z, flag_n;

   always #5 clk = ~clk;

   param_datapath #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
      .clk(clk), .clr(clr),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rc(cmd_rc), .cmd_imm(cmd_imm),
      .done(done), .err(err), .busy(busy),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .bus_contents(bus_contents), .flag_z(flag_z), .flag_n(flag_n)
   );

   typedef struct {
      logic [3:0]            op;
      logic [3:0]            ra;
      logic                  err;
      logic                  z;
      logic                  n;
      logic [NR-1:0][DW-1:0] regs;
      logic [31:0]           addr;
      logic                  we;
      logic [DW-1:0]         wdata;
      int                    acc;
      int                    lat;
   } exp_t;

   exp_t          q[$];
   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;
   int            ack_wait = 0;
   bit            stray_en = 1'b0;
   logic [DW-1:0] m_regs [NR];
   logic          m_z, m_n;
   logic [DW-1:0] m_mem   [MEMN];
   logic [DW-1:0] env_mem [MEMN];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic finish_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_z = 1'b0;
      m_n = 1'b0;
   endtask

   // Reference behaviour of one whole command, applied at acceptance.
   task automatic model_push(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                             input logic [3:0] rc, input logic [31:0] imm);
      exp_t        e;
      logic [31:0] a, b, r, base, sum;
      e.op = op; e.ra = ra; e.err = 1'b0; e.we = 1'b0; e.addr = 0; e.wdata = '0;
      e.acc = cyc; e.lat = -1;
      if (op > 4'd8) begin
         e.err = 1'b1;
         e.lat = 1;
      end else if (op == 4'd7 || op == 4'd8) begin
         base   = (rb == 4'd0) ? 32'd0 : m_regs[rb];
         sum    = base + imm;
         e.addr = sum % MEMN;
         if (op == 4'd8) begin
            e.we             = 1'b1;
            e.wdata          = m_regs[ra];
            m_mem[e.addr]    = m_regs[ra];
         end else begin
            m_regs[ra] = m_mem[e.addr];
         end
      end else begin
         a = m_regs[rb];
         b = (op == 4'd6) ? imm : m_regs[rc];
         case (op)
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a << (b % DW);
            4'd5:    r = a >> (b % DW);
            default: r = a + b;
         endcase
         m_regs[ra] = r;
         m_z        = (r == 32'd0);
         m_n        = (r >= 32'h8000_0000);
         e.lat      = 4;
      end
      e.z = m_z;
      e.n = m_n;
      for (int i = 0; i < NR; i++) e.regs[i] = m_regs[i];
      q.push_back(e);
   endtask

   task automatic issue(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rc, input logic [31:0] imm, input bit keep);
      logic r;
      int   n;
      cmd_valid = 1'b1;
      cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rc = rc; cmd_imm = imm;
      n = 0;
      forever begin
         r = cmd_ready;
         @(posedge clk);
         #1;
         if (r) break;
         n++;
         if (n > 200) begin
            total++; bad++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 within 200 cycles");
            finish_run();
         end
      end
      model_push(op, ra, rb, rc, imm);
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      cmd_valid = 1'b0;
      while (q.size() != 0 || cmd_ready !== 1'b1) begin
         @(negedge clk);
         n++;
         if (n > 1000) begin
            total++; bad++;
            $display("FAIL idle_timeout: got %0d outstanding expected 0", q.size());
            finish_run();
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Memory responder: acks after ack_wait cycles of mem_req, optional stray acks when idle.
   initial begin
      int wcnt;
      wcnt      = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_ack) begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
         end else if (mem_req === 1'b1 && !clr) begin
            if (wcnt >= ack_wait) begin
               mem_ack = 1'b1;
               if (mem_we) env_mem[mem_addr] = mem_wdata;
               else        mem_rdata = env_mem[mem_addr];
               wcnt = 0;
            end else begin
               wcnt++;
               mem_rdata = $urandom;
            end
         end else begin
            wcnt = 0;
            if (stray_en && ($urandom % 4 == 0)) mem_ack = 1'b1;
         end
      end
   end

   // Monitor: memory-port protocol and completion scoreboard.
   initial begin
      exp_t        e;
      logic        req_prev;
      logic [31:0] r_addr, r_wdata;
      logic        r_we;
      req_prev = 1'b0;
      r_addr = 0; r_wdata = 0; r_we = 1'b0;
      forever begin
         @(negedge clk);
         if (clr !== 1'b0) begin
            req_prev = 1'b0;
            continue;
         end
         if (mem_req) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL mem_req: got 1 expected 0 with nothing outstanding");
            end else if (!req_prev) begin
               check("mem_addr", 32'(mem_addr), q[0].addr);
               check("mem_we", 32'(mem_we), 32'(q[0].we));
               if (q[0].we) check("mem_wdata", mem_wdata, q[0].wdata);
               r_addr = 32'(mem_addr); r_we = mem_we; r_wdata = mem_wdata;
            end else begin
               check("mem_addr_hold", 32'(mem_addr), r_addr);
               check("mem_we_hold", 32'(mem_we), 32'(r_we));
               check("mem_wdata_hold", mem_wdata, r_wdata);
            end
         end
         req_prev = mem_req;
         if (err && !done) check("err_with_done", 32'(done), 32'd1);
         if (done) begin
            if (q.size() == 0) begin
               total++; bad++;
               $display("FAIL done: got unexpected pulse expected none outstanding");
            end else begin
               e = q.pop_front();
               check("err", 32'(err), 32'(e.err));
               check("flag_z", 32'(flag_z), 32'(e.z));
               check("flag_n", 32'(flag_n), 32'(e.n));
               check("ready_at_done", 32'(cmd_ready), 32'd1);
               if (e.lat > 0) check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
               for (int i = 0; i < NR; i++)
                  check($sformatf("R%0d", i), dut.regs_q[i], e.regs[i]);
               $display("txn op=%0d ra=%0d err=%0d lat=%0d z=%0d n=%0d",
                        e.op, e.ra, err, cyc - e.acc + 1, flag_z, flag_n);
            end
         end
      end
   end

   initial begin
      #2000000;
      total++; bad++;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      finish_run();
   end

   initial begin
      int n;
      logic [31:0] v;
      clr = 1'b1;
      cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rc = '0; cmd_imm = '0;
      for (int i = 0; i < MEMN; i++) begin
         v = $urandom;
         env_mem[i] = v;
         m_mem[i]   = v;
      end
      model_reset();
      repeat (3) @(posedge clk);
      #1 clr = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_flags", {30'd0, flag_z, flag_n}, 32'd0);
      check("rst_bus", bus_contents, 32'd0);
      for (int i = 0; i < NR; i++) check($sformatf("rst_R%0d", i), dut.regs_q[i], 32'd0);
      @(posedge clk);
      #1;

      // ADD 5 + 7
      issue(4'd6, 4'd1, 4'd0, 4'd0, 32'd5, 1'b0);
      issue(4'd6, 4'd2, 4'd0, 4'd0, 32'd7, 1'b0);
      issue(4'd0, 4'd3, 4'd1, 4'd2, 32'd0, 1'b0);
      wait_idle();
      check("add_R3", dut.regs_q[3], 32'd12);
      check("add_z", 32'(flag_z), 32'd0);

      // SUB to zero, then SUB to -1
      issue(4'd6, 4'd1, 4'd0, 4'd0, 32'd3, 1'b0);
      issue(4'd6, 4'd2, 4'd0, 4'd0, 32'd3, 1'b0);
      issue(4'd1, 4'd4, 4'd1, 4'd2, 32'd0, 1'b0);
      wait_idle();
      check("sub_R4_zero", dut.regs_q[4], 32'd0);
      check("sub_z", 32'(flag_z), 32'd1);
      issue(4'd6, 4'd1, 4'd0, 4'd0, 32'd0, 1'b0);
      issue(4'd6, 4'd2, 4'd0, 4'd0, 32'd1, 1'b0);
      issue(4'd1, 4'd4, 4'd1, 4'd2, 32'd0, 1'b0);
      wait_idle();
      check("sub_R4_neg", dut.regs_q[4], 32'hFFFF_FFFF);
      check("sub_n", 32'(flag_n), 32'd1);

      // Store with R0 base and three wait cycles
      issue(4'd6, 4'd5, 4'd0, 4'd0, 32'hA5A5_A5A5, 1'b0);
      ack_wait = 3;
      issue(4'd8, 4'd5, 4'd0, 4'd0, 32'h10, 1'b0);
      wait_idle();
      check("st_mem", env_mem[16], 32'hA5A5_A5A5);

      // Load from R2 base + 4
      env_mem[36] = 32'hDEAD_BEEF;
      m_mem[36]   = 32'hDEAD_BEEF;
      ack_wait = 1;
      issue(4'd6, 4'd2, 4'd0, 4'd0, 32'h20, 1'b0);
      issue(4'd7, 4'd6, 4'd2, 4'd0, 32'd4, 1'b0);
      wait_idle();
      check("ld_R6", dut.regs_q[6], 32'hDEAD_BEEF);

      // Illegal op, then commands presented back-to-back with valid held
      issue(4'd12, 4'd9, 4'd1, 4'd2, 32'd0, 1'b1);
      issue(4'd0, 4'd10, 4'd1, 4'd2, 32'd0, 1'b1);
      issue(4'd6, 4'd11, 4'd10, 4'd0, 32'd1, 1'b0);
      wait_idle();
      check("ill_R9", dut.regs_q[9], 32'd0);
      check("hold_R10", dut.regs_q[10], 32'h20);
      check("hold_R11", dut.regs_q[11], 32'h21);

      // Reset during an unanswered memory wait
      ack_wait = 100000;
      issue(4'd7, 4'd7, 4'd0, 4'd0, 32'h33, 1'b0);
      n = 0;
      while (mem_req !== 1'b1) begin
         @(posedge clk);
         #1;
         n++;
         if (n > 50) begin
            total++; bad++;
            $display("FAIL mem_req_timeout: got 0 expected 1 within 50 cycles");
            finish_run();
         end
      end
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("mem_wait_req", 32'(mem_req), 32'd1);
      clr = 1'b1;
      q.delete();
      model_reset();
      @(posedge clk);
      #1 clr = 1'b0;
      ack_wait = 0;
      @(negedge clk);
      check("clr_mem_req", 32'(mem_req), 32'd0);
      check("clr_mem_we", 32'(mem_we), 32'd0);
      check("clr_ready", 32'(cmd_ready), 32'd1);
      check("clr_done", 32'(done), 32'd0);
      check("clr_flags", {30'd0, flag_z, flag_n}, 32'd0);
      for (int i = 0; i < NR; i++) check($sformatf("clr_R%0d", i), dut.regs_q[i], 32'd0);
      @(posedge clk);
      #1;

      // Randomized traffic
      stray_en = 1'b1;
      for (int t = 0; t < 300; t++) begin
         logic [3:0] op;
         bit         keep;
         if ($urandom % 8 == 0) op = 4'($urandom_range(9, 15));
         else                   op = 4'($urandom_range(0, 8));
         ack_wait = $urandom_range(0, 3);
         keep     = 1'($urandom % 2);
         issue(op, 4'($urandom), 4'($urandom), 4'($urandom),
               ($urandom % 2) ? 32'($urandom) : 32'($urandom_range(0, 40)), keep);
         if (!keep) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
         end
      end
      wait_idle();
      finish_run();
   end

endmodule
